// File: rtl/reg_bank_scoreboard.sv
// Register bank with writeback bypass and per-register pending-write scoreboard.
// Decode is stalled while a source has an outstanding write or the destination counter is saturated.
module reg_bank_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREG   = 16,
  parameter int PEND_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pending_any,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam logic [PEND_W-1:0] CNT_MAX   = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CNT_ONE   = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs_r     [NREG];
  logic [PEND_W-1:0] cnt_r      [NREG];
  logic [PEND_W-1:0] cnt_next_s [NREG];
  logic              ovf_r;
  logic              unf_r;
  logic              pending_r;

  logic rs_hit_s;
  logic rt_hit_s;
  logic rd_hit_s;
  logic hazard_s;
  logic full_s;
  logic stall_s;
  logic accept_s;
  logic unf_set_s;
  logic any_next_s;
  logic inc_s;
  logic dec_s;

  // Operand read: r0 is zero, a same-cycle writeback wins over the stored value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              hit,
    input logic [DATA_W-1:0] bypass,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (addr == ZERO_ADDR) begin
      val = {DATA_W{1'b0}};
    end else if (hit) begin
      val = bypass;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Outstanding writes remaining once a same-cycle writeback retires one (never below zero).
  function automatic logic still_pending(input logic [PEND_W-1:0] cnt, input logic hit);
    return (cnt > (hit ? CNT_ONE : {PEND_W{1'b0}}));
  endfunction

  // Bypass matches, hazard/full detection and next counter values.
  always_comb begin
    rs_hit_s   = wb_we && (wb_rd == rs_addr);
    rt_hit_s   = wb_we && (wb_rd == rt_addr);
    rd_hit_s   = wb_we && (wb_rd == issue_rd);
    hazard_s   = ((rs_addr != ZERO_ADDR) && still_pending(cnt_r[rs_addr], rs_hit_s)) ||
                 ((rt_addr != ZERO_ADDR) && still_pending(cnt_r[rt_addr], rt_hit_s));
    full_s     = issue_we && (issue_rd != ZERO_ADDR) && (cnt_r[issue_rd] == CNT_MAX) && !rd_hit_s;
    stall_s    = issue_valid && (hazard_s || full_s);
    accept_s   = issue_valid && !stall_s;
    unf_set_s  = 1'b0;
    any_next_s = 1'b0;
    inc_s      = 1'b0;
    dec_s      = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_next_s[r] = cnt_r[r];
      if (r == 0) begin
        cnt_next_s[r] = {PEND_W{1'b0}};
      end else begin
        inc_s = accept_s && issue_we && (issue_rd == ADDR_W'(r));
        dec_s = wb_we && (wb_rd == ADDR_W'(r));
        case ({inc_s, dec_s})
          2'b10: cnt_next_s[r] = cnt_r[r] + CNT_ONE;
          2'b01: begin
            if (cnt_r[r] != {PEND_W{1'b0}}) begin
              cnt_next_s[r] = cnt_r[r] - CNT_ONE;
            end else begin
              unf_set_s = 1'b1;
            end
          end
          default: cnt_next_s[r] = cnt_r[r];
        endcase
      end
      any_next_s = any_next_s || (cnt_next_s[r] != {PEND_W{1'b0}});
    end
  end

  // Drive combinational read ports and stall.
  always_comb begin
    rs_data = read_port(rs_addr, rs_hit_s, wb_data, regs_r[rs_addr]);
    rt_data = read_port(rt_addr, rt_hit_s, wb_data, regs_r[rt_addr]);
    stall   = stall_s;
  end

  // State update: register file, counters and sticky flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_r[r] <= {DATA_W{1'b0}};
        cnt_r[r]  <= {PEND_W{1'b0}};
      end
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      if (wb_we && (wb_rd != ZERO_ADDR)) begin
        regs_r[wb_rd] <= wb_data;
      end
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= cnt_next_s[r];
      end
      ovf_r     <= ovf_r || (issue_valid && full_s);
      unf_r     <= unf_r || unf_set_s;
      pending_r <= any_next_s;
    end
  end

  assign pending_any = pending_r;
  assign ovf_err     = ovf_r;
  assign unf_err     = unf_r;

endmodule

// File: tb/tb_reg_bank_scoreboard.sv
// Bench for reg_bank_scoreboard: integer-level model checked every cycle plus directed literal checks.
module tb_reg_bank_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  rs_addr, rt_addr, issue_rd, wb_rd;
  logic [15:0] rs_data, rt_data, wb_data;
  logic        issue_valid, issue_we, stall, wb_we, pending_any, ovf_err, unf_err;

  int checks = 0;
  int errors = 0;

  reg_bank_scoreboard dut (
    .clock(clock), .reset_n(reset_n),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd), .stall(stall),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .pending_any(pending_any), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clock = ~clock;

  // Model state: plain values and counts
  logic [15:0] mreg [16];
  int          mcnt [16];
  bit          m_ovf = 1'b0, m_unf = 1'b0, model_ok = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input int a);
    if (a == 0) return 16'h0000;
    if (wb_we && int'(wb_rd) == a) return wb_data;
    return mreg[a];
  endfunction

  function automatic int m_left(input int r);
    int n;
    if (r == 0) return 0;
    n = mcnt[r] - ((wb_we && int'(wb_rd) == r) ? 1 : 0);
    return (n < 0) ? 0 : n;
  endfunction

  function automatic bit m_full();
    return issue_we && issue_rd != 4'd0 && mcnt[issue_rd] == 3 && m_left(int'(issue_rd)) == 3;
  endfunction

  function automatic bit m_stall();
    return issue_valid && ((m_left(int'(rs_addr)) > 0) || (m_left(int'(rt_addr)) > 0) || m_full());
  endfunction

  function automatic bit m_any();
    for (int r = 1; r < 16; r++) if (mcnt[r] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Model update on each rising edge
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int r = 0; r < 16; r++) begin mreg[r] = 16'h0000; mcnt[r] = 0; end
      m_ovf = 1'b0; m_unf = 1'b0; model_ok = 1'b1;
    end else begin
      int d;
      bit acc;
      acc = issue_valid && !m_stall();
      if (issue_valid && m_full()) m_ovf = 1'b1;
      for (int r = 1; r < 16; r++) begin
        d = mcnt[r] + ((acc && issue_we && int'(issue_rd) == r) ? 1 : 0)
                    - ((wb_we && int'(wb_rd) == r) ? 1 : 0);
        if (d < 0) begin d = 0; m_unf = 1'b1; end
        mcnt[r] = d;
      end
      if (wb_we && wb_rd != 4'd0) mreg[wb_rd] = wb_data;
    end
  end

  // Compare process: all outputs against the model mid-cycle
  always @(negedge clock) begin
    if (model_ok) begin
      chk("m_rs_data", rs_data, m_read(int'(rs_addr)));
      chk("m_rt_data", rt_data, m_read(int'(rt_addr)));
      chk("m_stall", {15'd0, stall}, {15'd0, m_stall()});
      chk("m_pending_any", {15'd0, pending_any}, {15'd0, m_any()});
      chk("m_ovf_err", {15'd0, ovf_err}, {15'd0, m_ovf});
      chk("m_unf_err", {15'd0, unf_err}, {15'd0, m_unf});
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 4'd0;
    wb_we = 1'b0; wb_rd = 4'd0; wb_data = 16'h0000;
    rs_addr = 4'd0; rt_addr = 4'd0;
  endtask

  task automatic issue(input logic [3:0] rd);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd;
  endtask

  task automatic wb(input logic [3:0] rd, input logic [15:0] data);
    wb_we = 1'b1; wb_rd = rd; wb_data = data;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    cyc(); cyc();
    reset_n = 1'b1;
    #2;
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_pending", {15'd0, pending_any}, 16'd0);
    chk("rst_ovf", {15'd0, ovf_err}, 16'd0);
    chk("rst_unf", {15'd0, unf_err}, 16'd0);
    for (int a = 1; a < 16; a++) begin
      rs_addr = 4'(a); rt_addr = 4'(16 - a);
      #1;
      chk("rst_read_rs", rs_data, 16'h0000);
      chk("rst_read_rt", rt_data, 16'h0000);
    end
    cyc();

    // Write r3 with bypass, then read from storage (cnt[3]==0 so unf_err fires)
    idle(); wb(4'd3, 16'hBEEF); rs_addr = 4'd3; #2;
    chk("bypass_rs", rs_data, 16'hBEEF);
    cyc();
    idle(); rt_addr = 4'd3; rs_addr = 4'd3; #2;
    chk("stored_rs", rs_data, 16'hBEEF);
    chk("stored_rt", rt_data, 16'hBEEF);
    chk("unf_after_r3", {15'd0, unf_err}, 16'd1);
    cyc();

    // RAW hazard on r5, released by same-cycle writeback
    idle(); issue(4'd5); #2;
    chk("issue5_stall", {15'd0, stall}, 16'd0);
    cyc();
    idle(); issue_valid = 1'b1; rs_addr = 4'd5; #2;
    chk("raw5_stall", {15'd0, stall}, 16'd1);
    chk("raw5_pending", {15'd0, pending_any}, 16'd1);
    cyc();
    wb(4'd5, 16'h0042); #2;
    chk("raw5_release", {15'd0, stall}, 16'd0);
    chk("raw5_bypass", rs_data, 16'h0042);
    cyc();
    idle(); #2;
    chk("cnt5_zero", {15'd0, pending_any}, 16'd0);
    cyc();

    // Saturate r7, refused 4th issue, then 4th issue with same-cycle writeback
    for (int i = 0; i < 3; i++) begin
      idle(); issue(4'd7); #2;
      chk("issue7_ok", {15'd0, stall}, 16'd0);
      cyc();
    end
    idle(); issue(4'd7); #2;
    chk("issue7_full", {15'd0, stall}, 16'd1);
    chk("ovf_before", {15'd0, ovf_err}, 16'd0);
    cyc();
    #2;
    chk("ovf_set", {15'd0, ovf_err}, 16'd1);
    wb(4'd7, 16'h1234); #1;
    chk("issue7_wb_ok", {15'd0, stall}, 16'd0);
    cyc();
    idle(); issue(4'd7); #2;
    chk("cnt7_still3", {15'd0, stall}, 16'd1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      idle(); wb(4'd7, 16'(16'h0700 + i)); cyc();
    end
    idle(); rt_addr = 4'd7; #2;
    chk("cnt7_drained", {15'd0, pending_any}, 16'd0);
    chk("r7_last", rt_data, 16'h0702);
    cyc();

    // Underflow write to r9, and dropped write to r0
    idle(); wb(4'd9, 16'h5A5A); cyc();
    idle(); rs_addr = 4'd9; wb(4'd0, 16'hFFFF); rt_addr = 4'd0; #2;
    chk("r9_written", rs_data, 16'h5A5A);
    chk("r0_bypass_zero", rt_data, 16'h0000);
    chk("unf_sticky", {15'd0, unf_err}, 16'd1);
    chk("cnt9_zero", {15'd0, pending_any}, 16'd0);
    cyc();
    idle(); #2;
    chk("r0_zero", rs_data, 16'h0000);
    cyc();

    // Reset mid-operation with cnt[2]==2, writeback on the reset edge ignored
    idle(); wb(4'd2, 16'h2222); cyc();
    idle(); issue(4'd2); cyc();
    idle(); issue(4'd2); cyc();
    idle(); #2;
    chk("cnt2_pending", {15'd0, pending_any}, 16'd1);
    reset_n = 1'b0; wb(4'd4, 16'h1111);
    cyc();
    reset_n = 1'b1; idle(); rs_addr = 4'd2; rt_addr = 4'd4; #2;
    chk("rst2_r2", rs_data, 16'h0000);
    chk("rst2_r4", rt_data, 16'h0000);
    chk("rst2_pending", {15'd0, pending_any}, 16'd0);
    chk("rst2_unf", {15'd0, unf_err}, 16'd0);
    chk("rst2_ovf", {15'd0, ovf_err}, 16'd0);
    issue_valid = 1'b1; #1;
    chk("rst2_no_stall", {15'd0, stall}, 16'd0);
    cyc();

    // Mixed traffic checked only by the model
    for (int i = 0; i < 80; i++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_we    = 1'($urandom_range(0, 1));
      issue_rd    = 4'($urandom_range(0, 15));
      wb_we       = 1'($urandom_range(0, 1));
      wb_rd       = 4'($urandom_range(0, 15));
      wb_data     = 16'($urandom);
      rs_addr     = 4'($urandom_range(0, 15));
      rt_addr     = 4'($urandom_range(0, 15));
      cyc();
    end
    idle(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
